// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, write port, reservation port and busy status.
// The master is the issue/writeback side; the slave is the register file.
interface reg_file_sb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 2
);
    logic [AW-1:0]    rn_1;
    logic [AW-1:0]    rn_2;
    logic [WIDTH-1:0] rd_1;
    logic [WIDTH-1:0] rd_2;
    logic             busy_1;
    logic             busy_2;
    logic             w;
    logic [AW-1:0]    wn;
    logic [WIDTH-1:0] wd;
    logic             rsv;
    logic [AW-1:0]    rsv_n;
    logic             rsv_ack;
    logic             any_busy;

    modport master (
        output rn_1, rn_2, w, wn, wd, rsv, rsv_n,
        input  rd_1, rd_2, busy_1, busy_2, rsv_ack, any_busy
    );

    modport slave (
        input  rn_1, rn_2, w, wn, wd, rsv, rsv_n,
        output rd_1, rd_2, busy_1, busy_2, rsv_ack, any_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass and per-register busy scoreboard (REG_FILE_SB_ZERO_REG_EN hardwires reg 0 to zero).
// Latency: reads 0 cycles, write and reserve land on the next rising edge.
// Backpressure: none on reads/writes; a reserve of a busy register is refused (rsv_ack=0) and must be retried.
module reg_file_sb #(
    parameter int               WIDTH     = 16,
    parameter int               AW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave rf
);
    localparam int NREGS = 2 ** AW;

`ifdef REG_FILE_SB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_eff;
    logic             wr_en;

    assign wr_en = rf.w && !rst && !(ZERO_REG && rf.wn == '0);

    // A write in flight releases its register's owner in the same cycle.
    always_comb begin
        busy_eff = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_eff[i] = busy[i] && !(wr_en && rf.wn == AW'(i));
        end
    end

    always_comb begin
        rf.rd_1 = regs[rf.rn_1];
        if (wr_en && rf.wn == rf.rn_1) begin
            rf.rd_1 = rf.wd;
        end
        if (ZERO_REG && rf.rn_1 == '0) begin
            rf.rd_1 = '0;
        end
    end

    always_comb begin
        rf.rd_2 = regs[rf.rn_2];
        if (wr_en && rf.wn == rf.rn_2) begin
            rf.rd_2 = rf.wd;
        end
        if (ZERO_REG && rf.rn_2 == '0) begin
            rf.rd_2 = '0;
        end
    end

    assign rf.busy_1   = busy_eff[rf.rn_1];
    assign rf.busy_2   = busy_eff[rf.rn_2];
    assign rf.rsv_ack  = rf.rsv && !rst && !busy_eff[rf.rsv_n]
                         && !(ZERO_REG && rf.rsv_n == '0);
    assign rf.any_busy = |busy;

    // The reserve is applied after the write so a same-address pair ends busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (ZERO_REG && i == 0) ? '0 : RESET_VAL;
            end
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[rf.wn] <= rf.wd;
                busy[rf.wn] <= 1'b0;
            end
            if (rf.rsv_ack) begin
                busy[rf.rsv_n] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed steps plus a random burst, checked against a scoreboard queue.
module tb_reg_file_sb;
    localparam int          WIDTH = 16;
    localparam int          AW    = 2;
    localparam int          NREGS = 4;
    localparam logic [15:0] RV    = 16'h00A5;

`ifdef REG_FILE_SB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    typedef struct {
        logic [15:0] rd_1;
        logic [15:0] rd_2;
        logic        busy_1;
        logic        busy_2;
        logic        rsv_ack;
        logic        any_busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.WIDTH(WIDTH), .AW(AW)) rf ();

    reg_file_sb #(.WIDTH(WIDTH), .AW(AW), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    exp_t        sb [$];
    logic [15:0] m_reg [NREGS];
    logic [3:0]  m_busy;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic m_wr();
        return rf.w && !rst && !(ZR && rf.wn == 2'd0);
    endfunction

    function automatic logic [15:0] m_rd(input logic [AW-1:0] a);
        if (ZR && a == 2'd0) return 16'h0;
        if (m_wr() && rf.wn == a) return rf.wd;
        return m_reg[a];
    endfunction

    function automatic logic m_beff(input logic [AW-1:0] a);
        if (ZR && a == 2'd0) return 1'b0;
        return m_busy[a] && !(m_wr() && rf.wn == a);
    endfunction

    function automatic logic m_ack();
        return rf.rsv && !rst && !m_beff(rf.rsv_n) && !(ZR && rf.rsv_n == 2'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk("rd_1", 32'(rf.rd_1), 32'(e.rd_1));
            chk("rd_2", 32'(rf.rd_2), 32'(e.rd_2));
            chk("busy_1", 32'(rf.busy_1), 32'(e.busy_1));
            chk("busy_2", 32'(rf.busy_2), 32'(e.busy_2));
            chk("rsv_ack", 32'(rf.rsv_ack), 32'(e.rsv_ack));
            chk("any_busy", 32'(rf.any_busy), 32'(e.any_busy));
        end
    endtask

    task automatic drive(input logic r, input logic wv, input logic [AW-1:0] wnv,
                         input logic [15:0] wdv, input logic rv, input logic [AW-1:0] rnv,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(negedge clk);
        rst      = r;
        rf.w     = wv;
        rf.wn    = wnv;
        rf.wd    = wdv;
        rf.rsv   = rv;
        rf.rsv_n = rnv;
        rf.rn_1  = a1;
        rf.rn_2  = a2;
        e.rd_1     = m_rd(a1);
        e.rd_2     = m_rd(a2);
        e.busy_1   = m_beff(a1);
        e.busy_2   = m_beff(a2);
        e.rsv_ack  = m_ack();
        e.any_busy = |m_busy;
        sb.push_back(e);
        #1;
        check_out();
    endtask

    task automatic tick();
        logic wr;
        logic ack;
        @(posedge clk);
        wr  = m_wr();
        ack = m_ack();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_reg[i] = (ZR && i == 0) ? 16'h0 : RV;
            m_busy = 4'b0;
        end else begin
            if (wr) begin
                m_reg[rf.wn]  = rf.wd;
                m_busy[rf.wn] = 1'b0;
            end
            if (ack) m_busy[rf.rsv_n] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        rf.w = 1'b0; rf.wn = 2'd0; rf.wd = 16'h0;
        rf.rsv = 1'b0; rf.rsv_n = 2'd0; rf.rn_1 = 2'd0; rf.rn_2 = 2'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NREGS; i++) m_reg[i] = (ZR && i == 0) ? 16'h0 : RV;
        m_busy = 4'b0;

        drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd0, 2'd0);
        chk("ack_in_reset", 32'(rf.rsv_ack), 32'd0);
        tick();

        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd2, 2'd3);
        chk("reset_rd_1", 32'(rf.rd_1), 32'h00A5);
        chk("reset_rd_2", 32'(rf.rd_2), 32'h00A5);
        chk("reset_busy", 32'({rf.busy_1, rf.busy_2}), 32'd0);
        chk("reset_any_busy", 32'(rf.any_busy), 32'd0);
        tick();

        drive(1'b0, 1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 2'd2, 2'd1);
        chk("bypass_rd_1", 32'(rf.rd_1), 32'h1234);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd2, 2'd1);
        chk("stored_rd_1", 32'(rf.rd_1), 32'h1234);
        tick();

        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 2'd0, 2'd1);
        chk("rsv3_ack", 32'(rf.rsv_ack), 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 2'd3, 2'd1);
        chk("rsv3_busy_1", 32'(rf.busy_1), 32'd1);
        chk("rsv3_any_busy", 32'(rf.any_busy), 32'd1);
        chk("rsv3_retry_nack", 32'(rf.rsv_ack), 32'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd3, 2'd1);
        chk("rsv3_still_busy", 32'(rf.busy_1), 32'd1);
        tick();

        drive(1'b0, 1'b1, 2'd3, 16'hBEEF, 1'b0, 2'd0, 2'd0, 2'd3);
        chk("wb3_busy_2", 32'(rf.busy_2), 32'd0);
        chk("wb3_rd_2", 32'(rf.rd_2), 32'hBEEF);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd3);
        chk("wb3_after_busy_2", 32'(rf.busy_2), 32'd0);
        chk("wb3_after_any_busy", 32'(rf.any_busy), 32'd0);
        tick();

        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd1, 2'd0);
        tick();
        drive(1'b0, 1'b1, 2'd1, 16'h0F0F, 1'b1, 2'd1, 2'd1, 2'd0);
        chk("wr_rsv_same_ack", 32'(rf.rsv_ack), 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd1, 2'd0);
        chk("wr_rsv_same_rd", 32'(rf.rd_1), 32'h0F0F);
        chk("wr_rsv_same_busy", 32'(rf.busy_1), 32'd1);
        tick();

        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd0, 2'd0);
        tick();
        drive(1'b1, 1'b1, 2'd2, 16'hFFFF, 1'b1, 2'd3, 2'd2, 2'd2);
        chk("rst_wr_ack", 32'(rf.rsv_ack), 32'd0);
        chk("rst_no_bypass", 32'(rf.rd_1), 32'h1234);
        chk("rst_stored_busy", 32'(rf.busy_2), 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd2, 2'd1);
        chk("post_rst_rd", 32'(rf.rd_1), 32'h00A5);
        chk("post_rst_busy", 32'({rf.busy_1, rf.busy_2}), 32'd0);
        chk("post_rst_any_busy", 32'(rf.any_busy), 32'd0);
        tick();

        drive(1'b0, 1'b1, 2'd0, 16'h5555, 1'b1, 2'd0, 2'd0, 2'd0);
        chk("reg0_bypass", 32'(rf.rd_1), ZR ? 32'h0 : 32'h5555);
        chk("reg0_rsv_ack", 32'(rf.rsv_ack), ZR ? 32'd0 : 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0, 2'd1);
        chk("reg0_stored", 32'(rf.rd_1), ZR ? 32'h0 : 32'h5555);
        chk("reg0_busy", 32'(rf.busy_1), ZR ? 32'd0 : 32'd1);
        tick();

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom), AW'($urandom), 16'($urandom),
                  1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
            tick();
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 4x16 two-read/one-write register block. Register count and width are parameters, with write-to-read bypass. Adds a per-register busy scoreboard so a multi-cycle unit can reserve its destination register at issue and release it at writeback. Sits between the decoder/issue logic and the ALU/load units of the datapath.

Parameters:
WIDTH, 16, data width of each register
AW, 2, register address width; register count NREGS = 2**AW
RESET_VAL, 0, value loaded into every register on reset (WIDTH bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
rn_1  input  AW  read address, port 1
rn_2  input  AW  read address, port 2
rd_1  output  WIDTH  read data, port 1 (combinational)
rd_2  output  WIDTH  read data, port 2 (combinational)
busy_1  output  1  effective busy flag of register rn_1
busy_2  output  1  effective busy flag of register rn_2
w  input  1  write enable
wn  input  AW  write address
wd  input  WIDTH  write data
rsv  input  1  reserve request
rsv_n  input  AW  register to reserve
rsv_ack  output  1  reservation granted this cycle (combinational)
any_busy  output  1  at least one busy bit set (registered state, combinational OR)

Behaviour:
- State: NREGS x WIDTH data registers; NREGS busy bits.
- Reset (rst=1 at edge): all registers <= RESET_VAL; all busy <= 0. While rst=1: w and rsv ignored, rsv_ack=0, bypass disabled. rd_x shows stored contents, busy_x shows stored bits. Reset during a pending reservation discards it.
- Reset values of outputs (first cycle after reset, w=rsv=0): rd_1=rd_2=RESET_VAL, busy_1=busy_2=0, rsv_ack=0, any_busy=0.
- Write: w=1 at edge -> reg[wn] <= wd and busy[wn] <= 0. Writing a non-busy register is legal (plain write).
- Read: rd_x = (w && wn==rn_x && !rst) ? wd : reg[rn_x]. This is write-through bypass with zero latency. Stored value is visible from the next cycle.
- Effective busy: busy_eff(a) = busy[a] && !(w && wn==a && !rst). busy_x = busy_eff(rn_x).
- Reserve: rsv_ack = rsv && !rst && !busy_eff(rsv_n). If granted, busy[rsv_n] <= 1 at the edge. If rejected (register still busy), no state change; the requester retries.
- Simultaneous write and reserve, same address: write data stored; busy ends at 1 (the new reservation wins). rsv_ack=1 because the write releases the old owner this cycle.
- Simultaneous write and reserve, different addresses: both take effect independently.
- rn_1==rn_2: both ports return identical data and busy.
- Address range: all 2**AW addresses valid. No out-of-range case.
- any_busy = OR of the stored busy bits. It does not include same-cycle updates.
- Latency summary: read 0 cycles, write-to-storage 1 edge, reserve-to-busy 1 edge.

Optional Feature:
Macro REG_FILE_SB_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - rd_x=0 when rn_x=0, including when bypass would apply.
  - Writes to address 0 are dropped.
  - busy[0] is constant 0; busy_x=0 for address 0.
  - Reservation of address 0 is always rejected (rsv_ack=0).
  - RESET_VAL is not applied to register 0.
- Not defined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset then idle, WIDTH=16 AW=2 RESET_VAL=16'h00A5 -> rd_1=rd_2=16'h00A5, busy_1=busy_2=0, any_busy=0.
- w=1 wn=2 wd=16'h1234, rn_1=2 in same cycle -> rd_1=16'h1234 that cycle (bypass). After the edge with w=0 -> rd_1=16'h1234 from storage.
- rsv=1 rsv_n=3 -> rsv_ack=1; next cycle busy_1=1 (rn_1=3), any_busy=1. Then rsv=1 rsv_n=3 again -> rsv_ack=0, state unchanged.
- Register 3 busy; w=1 wn=3 wd=16'hBEEF with rn_2=3 -> busy_2=0 and rd_2=16'hBEEF same cycle. Next cycle busy_2=0, any_busy=0.
- Register 1 busy; same cycle w=1 wn=1 wd=16'h0F0F and rsv=1 rsv_n=1 -> rsv_ack=1; next cycle reg1=16'h0F0F and busy_1=1.
- Reserve reg 2, then rst=1 together with w=1 wn=2 wd=16'hFFFF -> after the edge reg2=RESET_VAL, busy cleared, rsv_ack=0 during reset. With REG_FILE_SB_ZERO_REG_EN defined: write 16'h5555 to addr 0 -> rd_1=0 when rn_1=0; rsv_n=0 -> rsv_ack=0.
